// File: rtl/hpi_access_sequencer.sv
`timescale 1ns/1ps
// Single-word HPI bus master: sequences setup, strobe, hold and recovery
// phases around one request and returns captured read data.
module hpi_access_sequencer #(
   parameter int unsigned SETUP_CYC    = 1,
   parameter int unsigned STROBE_CYC   = 4,
   parameter int unsigned HOLD_CYC     = 2,
   parameter int unsigned RECOVERY_CYC = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic [1:0]  hpi_address,
   output logic [15:0] hpi_data_out,
   input  logic [15:0] hpi_data_in,
   output logic        hpi_r,
   output logic        hpi_w,
   output logic        hpi_cs
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      RECOVER
   } state_t;

   localparam logic [3:0] SETUP_LD    = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD   = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD     = 4'(HOLD_CYC - 1);
   localparam logic [3:0] RECOVERY_LD = 4'(RECOVERY_CYC - 1);
   // Counter value during the 2nd HOLD cycle: data-in lags the bus by two registers.
   localparam logic [3:0] CAPTURE_AT  = 4'(HOLD_CYC - 2);

   state_t     state;
   logic [3:0] cnt;
   logic       is_write;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         cnt          <= '0;
         is_write     <= 1'b0;
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         hpi_address  <= '0;
         hpi_data_out <= '0;
         hpi_r        <= 1'b1;
         hpi_w        <= 1'b1;
         hpi_cs       <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  is_write     <= req_write;
                  hpi_address  <= req_addr;
                  hpi_data_out <= req_wdata;
                  hpi_cs       <= 1'b0;
                  req_ready    <= 1'b0;
                  cnt          <= SETUP_LD;
                  state        <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  hpi_w <= ~is_write;
                  hpi_r <= is_write;
                  cnt   <= STROBE_LD;
                  state <= STROBE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            STROBE: begin
               if (cnt == '0) begin
                  hpi_w <= 1'b1;
                  hpi_r <= 1'b1;
                  cnt   <= HOLD_LD;
                  state <= HOLD;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            HOLD: begin
               if (!is_write && cnt == CAPTURE_AT) begin
                  rsp_rdata <= hpi_data_in;
               end
               if (cnt == '0) begin
                  hpi_cs    <= 1'b1;
                  rsp_valid <= 1'b1;
                  cnt       <= RECOVERY_LD;
                  state     <= RECOVER;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RECOVER: begin
               rsp_valid <= 1'b0;
               if (cnt == '0) begin
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hpi_access_sequencer.sv
`timescale 1ns/1ps
// Bench: lane 0 uses default timing, lane 1 uses SETUP=2 STROBE=1 HOLD=3 RECOVERY=1.
// Each lane has an HPI interface model and a timing/scoreboard model.
module tb_hpi_access_sequencer;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   logic [1:0]       rst;
   logic [1:0]       req_valid;
   logic [1:0]       req_write;
   logic [1:0][1:0]  req_addr;
   logic [1:0][15:0] req_wdata;
   logic [1:0][15:0] chip_data;
   logic [1:0]       req_ready;
   logic [1:0]       rsp_valid;

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int S = (g == 0) ? 1 : 2;
      localparam int T = (g == 0) ? 4 : 1;
      localparam int H = (g == 0) ? 2 : 3;
      localparam int R = (g == 0) ? 2 : 1;

      logic [15:0] rsp_rdata;
      logic [15:0] hpi_data_out;
      logic [15:0] data_in_q;
      logic [1:0]  hpi_address;
      logic        hpi_r, hpi_w, hpi_cs;
      logic        otg_rd_n;

      hpi_access_sequencer #(
         .SETUP_CYC   (S),
         .STROBE_CYC  (T),
         .HOLD_CYC    (H),
         .RECOVERY_CYC(R)
      ) dut (
         .Clk         (Clk),
         .Reset       (rst[g]),
         .req_valid   (req_valid[g]),
         .req_ready   (req_ready[g]),
         .req_write   (req_write[g]),
         .req_addr    (req_addr[g]),
         .req_wdata   (req_wdata[g]),
         .rsp_valid   (rsp_valid[g]),
         .rsp_rdata   (rsp_rdata),
         .hpi_address (hpi_address),
         .hpi_data_out(hpi_data_out),
         .hpi_data_in (data_in_q),
         .hpi_r       (hpi_r),
         .hpi_w       (hpi_w),
         .hpi_cs      (hpi_cs)
      );

      // Interface model: OTG_RD_N lags hpi_r by one cycle, data-in lags the bus by one more.
      always @(posedge Clk) begin
         otg_rd_n  <= hpi_r;
         data_in_q <= (otg_rd_n === 1'b0) ? chip_data[g] : 16'h5A5A;
      end

      logic [15:0] sb[$];
      int          acc = -1000;
      bit          armed = 1'b0;
      bit          exp_write = 1'b0;
      logic [1:0]  exp_addr = '0;
      logic [15:0] exp_data = '0;
      logic [15:0] last_read = '0;

      always @(negedge Clk) begin
         int d;
         bit busy;
         bit strobe;
         d      = cyc - acc;
         busy   = d < S + T + H + R;
         strobe = (d >= S) && (d < S + T);
         if (armed) begin
            check($sformatf("L%0d cs", g), 32'(hpi_cs), (d < S + T + H) ? 0 : 1);
            check($sformatf("L%0d w", g), 32'(hpi_w), 32'(!(strobe && exp_write)));
            check($sformatf("L%0d r", g), 32'(hpi_r), 32'(!(strobe && !exp_write)));
            check($sformatf("L%0d rsp_valid", g), 32'(rsp_valid[g]), 32'(d == S + T + H));
            check($sformatf("L%0d req_ready", g), 32'(req_ready[g]), 32'(!busy));
            check($sformatf("L%0d addr", g), 32'(hpi_address), 32'(exp_addr));
            check($sformatf("L%0d dout", g), 32'(hpi_data_out), 32'(exp_data));
            if (rsp_valid[g] === 1'b1) begin
               if (sb.size() == 0) check($sformatf("L%0d rsp_unexpected", g), 32'(rsp_valid[g]), 0);
               else check($sformatf("L%0d rsp_rdata", g), 32'(rsp_rdata), 32'(sb.pop_front()));
            end
         end
         if (rst[g]) begin
            armed     = 1'b1;
            acc       = -1000;
            exp_addr  = '0;
            exp_data  = '0;
            last_read = '0;
            sb.delete();
         end else if (armed && !busy && req_valid[g]) begin
            acc       = cyc + 1;
            exp_write = req_write[g];
            exp_addr  = req_addr[g];
            exp_data  = req_wdata[g];
            if (!req_write[g]) last_read = chip_data[g];
            sb.push_back(last_read);
         end
      end
   end

   task automatic do_req(input int l, input bit wr, input logic [1:0] a, input logic [15:0] wd,
                         input bit keep, output int acc_edge);
      int n;
      @(posedge Clk); #1;
      req_valid[l] = 1'b1;
      req_write[l] = wr;
      req_addr[l]  = a;
      req_wdata[l] = wd;
      n = 0;
      @(negedge Clk);
      while (!req_ready[l] && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (!req_ready[l]) check($sformatf("L%0d ready_timeout", l), 32'(req_ready[l]), 1);
      @(posedge Clk); #1;
      acc_edge = cyc;
      if (!keep) req_valid[l] = 1'b0;
   endtask

   task automatic wait_rsp(input int l, input int a, input int exp_lat);
      int n;
      n = 0;
      @(negedge Clk);
      while (!rsp_valid[l] && n < 60) begin
         @(negedge Clk);
         n++;
      end
      check($sformatf("L%0d rsp_seen", l), 32'(rsp_valid[l]), 1);
      check($sformatf("L%0d rsp_latency", l), 32'(cyc - a), 32'(exp_lat));
   endtask

   initial begin
      int a1, a2;
      rst       = '1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      chip_data = '0;
      repeat (3) @(posedge Clk);
      #1 rst = '0;
      repeat (2) @(posedge Clk);

      // write addr=2 data=0x1234
      do_req(0, 1'b1, 2'd2, 16'h1234, 1'b0, a1);
      wait_rsp(0, a1, 7);

      // read addr=0 returning 0xBEEF
      chip_data[0] = 16'hBEEF;
      do_req(0, 1'b0, 2'd0, 16'h0000, 1'b0, a1);
      wait_rsp(0, a1, 7);

      // back-to-back: write 0x0001 then read, valid held high
      chip_data[0] = 16'hC0DE;
      do_req(0, 1'b1, 2'd1, 16'h0001, 1'b1, a1);
      do_req(0, 1'b0, 2'd3, 16'h0000, 1'b0, a2);
      check("L0 b2b_gap", 32'(a2 - a1), 10);
      wait_rsp(0, a2, 7);

      // busy: request fields change and valid pulses during STROBE
      do_req(0, 1'b1, 2'd1, 16'h5555, 1'b0, a1);
      repeat (2) @(posedge Clk);
      #1;
      req_addr[0]  = 2'd3;
      req_wdata[0] = 16'hFFFF;
      req_valid[0] = 1'b1;
      req_write[0] = 1'b0;
      @(posedge Clk); #1;
      req_valid[0] = 1'b0;
      wait_rsp(0, a1, 7);
      repeat (15) @(posedge Clk);

      // reset during the 2nd STROBE cycle of a read
      chip_data[0] = 16'h1111;
      do_req(0, 1'b0, 2'd0, 16'h0000, 1'b0, a1);
      repeat (2) @(posedge Clk);
      #1 rst[0] = 1'b1;
      @(posedge Clk); #1 rst[0] = 1'b0;
      repeat (12) @(posedge Clk);
      chip_data[0] = 16'h2222;
      do_req(0, 1'b0, 2'd3, 16'h0000, 1'b0, a1);
      wait_rsp(0, a1, 7);

      // alternate timing lane: read then write
      chip_data[1] = 16'hBEEF;
      do_req(1, 1'b0, 2'd0, 16'h0000, 1'b0, a1);
      wait_rsp(1, a1, 6);
      do_req(1, 1'b1, 2'd2, 16'hA5C3, 1'b0, a1);
      wait_rsp(1, a1, 6);
      chip_data[1] = 16'h7E81;
      do_req(1, 1'b0, 2'd1, 16'h0000, 1'b0, a1);
      wait_rsp(1, a1, 6);

      repeat (12) @(posedge Clk);
      check("L0 sb_empty", 32'(lane[0].sb.size()), 0);
      check("L1 sb_empty", 32'(lane[1].sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
